id_stage_pipe: RTL and testbench

Registered, parametrised instruction-decode stage for the Jeriscv RV32I pipeline. It sits between the IF/ID boundary and EX. It decodes one instruction per cycle into operand, jump-operand and write-back fields, and holds the result in an ID/EX output register under a valid/ready handshake. It also provides load-use interlock, flush and a saturating stall counter that a purely combinational decoder cannot.

---
 rtl/id_stage_pipe_pkg.sv | 75 +++++++
 rtl/id_stage_pipe_decode.sv | 165 ++++++++++++++++
 rtl/id_stage_pipe.sv | 151 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode constants, ALU operation encodings and the decoded control bundle.
// Optional M-extension decode is enabled with JERISCV_M_EXT_EN (used by id_decode_comb).
package id_stage_pipe_pkg;

  localparam logic [6:0] OPC_NOP    = 7'h00;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MEXT = 7'h01;

  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SLT    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_OR     = 5'd9,
    ALU_AND    = 5'd10,
    ALU_BEQ    = 5'd11,
    ALU_BNE    = 5'd12,
    ALU_BLT    = 5'd13,
    ALU_BGE    = 5'd14,
    ALU_BLTU   = 5'd15,
    ALU_BGEU   = 5'd16,
    ALU_MUL    = 5'd17,
    ALU_MULH   = 5'd18,
    ALU_MULHSU = 5'd19,
    ALU_MULHU  = 5'd20,
    ALU_DIV    = 5'd21,
    ALU_DIVU   = 5'd22,
    ALU_REM    = 5'd23,
    ALU_REMU   = 5'd24
  } alu_op_e;

  typedef struct packed {
    logic    we;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    illegal;
    alu_op_e alu_op;
  } dec_ctrl_t;

  // Integer ALU op selected by funct3; alt picks SUB/SRA.
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// id_decode_comb: purely combinational RV32I decoder producing the ID/EX bundle and rs-used flags.
// Define JERISCV_M_EXT_EN to decode MUL..REMU; otherwise those encodings are illegal.
module id_decode_comb
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [XLEN-1:0]   o_op1,
  output logic [XLEN-1:0]   o_op2,
  output logic [XLEN-1:0]   o_op1_jump,
  output logic [XLEN-1:0]   o_op2_jump,
  output logic [XLEN-1:0]   o_rs2_data,
  output dec_ctrl_t         o_ctrl,
  output logic              o_rs1_used,
  output logic              o_rs2_used
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;

  assign opcode = i_inst[6:0];
  assign f3     = i_inst[14:12];
  assign f7     = i_inst[31:25];
  assign rd     = i_inst[11:7];
  assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u  = {i_inst[31:12], 12'h000};
  assign imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    o_wr_addr  = '0;
    o_op1      = '0;
    o_op2      = '0;
    o_op1_jump = '0;
    o_op2_jump = '0;
    o_rs2_data = '0;
    o_ctrl     = '{alu_op: ALU_NOP, default: '0};
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    legal      = 1'b1;

    case (opcode)
      OPC_NOP: ;
      OPC_OP: begin
        o_op1 = i_rs1_data;
        o_op2 = i_rs2_data;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        o_ctrl.we  = 1'b1;
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)))
          o_ctrl.alu_op = alu_base(f3, f7[5]);
`ifdef JERISCV_M_EXT_EN
        else if (f7 == F7_MEXT)
          o_ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
`endif
        else
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        o_op1 = i_rs1_data;
        o_op2 = XLEN'($signed(imm_i));
        o_rs1_used = 1'b1;
        o_ctrl.we  = 1'b1;
        // Only shift-immediates carry a funct7; for the rest bit 30 is immediate data.
        o_ctrl.alu_op = alu_base(f3, f3 == F3_SR && f7[5]);
        if (f3 == F3_SLL) legal = (f7 == F7_BASE);
        if (f3 == F3_SR)  legal = (f7 == F7_BASE || f7 == F7_ALT);
      end
      OPC_LOAD: begin
        o_op1 = i_rs1_data;
        o_op2 = XLEN'($signed(imm_i));
        o_rs1_used     = 1'b1;
        o_ctrl.we      = 1'b1;
        o_ctrl.is_load = 1'b1;
        o_ctrl.alu_op  = ALU_ADD;
        legal = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      end
      OPC_STORE: begin
        o_op1      = i_rs1_data;
        o_op2      = XLEN'($signed(imm_s));
        o_rs2_data = i_rs2_data;
        o_rs1_used      = 1'b1;
        o_rs2_used      = 1'b1;
        o_ctrl.is_store = 1'b1;
        o_ctrl.alu_op   = ALU_ADD;
        legal = (f3 <= 3'd2);
      end
      OPC_BRANCH: begin
        o_op1      = i_rs1_data;
        o_op2      = i_rs2_data;
        o_op1_jump = i_pc;
        o_op2_jump = XLEN'($signed(imm_b));
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
        o_ctrl.is_branch = 1'b1;
        case (f3)
          3'd0:    o_ctrl.alu_op = ALU_BEQ;
          3'd1:    o_ctrl.alu_op = ALU_BNE;
          3'd4:    o_ctrl.alu_op = ALU_BLT;
          3'd5:    o_ctrl.alu_op = ALU_BGE;
          3'd6:    o_ctrl.alu_op = ALU_BLTU;
          3'd7:    o_ctrl.alu_op = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        o_op2 = XLEN'($signed(imm_u));
        o_ctrl.we     = 1'b1;
        o_ctrl.alu_op = ALU_ADD;
      end
      OPC_AUIPC: begin
        o_op1 = i_pc;
        o_op2 = XLEN'($signed(imm_u));
        o_ctrl.we     = 1'b1;
        o_ctrl.alu_op = ALU_ADD;
      end
      OPC_JAL: begin
        o_op1      = i_pc;
        o_op2      = XLEN'(4);
        o_op1_jump = i_pc;
        o_op2_jump = XLEN'($signed(imm_j));
        o_ctrl.we     = 1'b1;
        o_ctrl.alu_op = ALU_ADD;
      end
      OPC_JALR: begin
        o_op1      = i_pc;
        o_op2      = XLEN'(4);
        o_op1_jump = i_rs1_data;
        o_op2_jump = XLEN'($signed(imm_i));
        o_rs1_used    = 1'b1;
        o_ctrl.we     = 1'b1;
        o_ctrl.alu_op = ALU_ADD;
        legal = (f3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      o_op1      = '0;
      o_op2      = '0;
      o_op1_jump = '0;
      o_op2_jump = '0;
      o_rs2_data = '0;
      o_ctrl     = '{alu_op: ALU_NOP, default: '0};
      o_ctrl.illegal = 1'b1;
      o_rs1_used = 1'b0;
      o_rs2_used = 1'b0;
    end else if (opcode != OPC_NOP) begin
      o_wr_addr = REG_AW'(rd);
    end

    if (rd == 5'd0) o_ctrl.we = 1'b0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: valid/ready ID/EX register, load-use interlock, flush and stall counter.
// JERISCV_M_EXT_EN (see id_decode_comb) enables M-extension decode.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_inst_addr,
  output logic [REG_AW-1:0] o_reg1_raddr,
  output logic [REG_AW-1:0] o_reg2_raddr,
  input  logic [XLEN-1:0]   i_reg1_data,
  input  logic [XLEN-1:0]   i_reg2_data,
  input  logic              i_ex_load,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_reg_we,
  output logic [REG_AW-1:0] o_reg_wr_addr,
  output logic [XLEN-1:0]   o_op1,
  output logic [XLEN-1:0]   o_op2,
  output logic [XLEN-1:0]   o_op1_jump,
  output logic [XLEN-1:0]   o_op2_jump,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [4:0]        o_alu_op,
  output logic              o_is_load,
  output logic              o_is_store,
  output logic              o_is_branch,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic [REG_AW-1:0] dec_wr_addr;
  logic [XLEN-1:0]   dec_op1, dec_op2, dec_op1_jump, dec_op2_jump, dec_rs2_data;
  dec_ctrl_t         dec_ctrl;
  logic              rs1_used, rs2_used;
  logic              hazard, accept;

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]   op1_jump_q, op1_jump_d, op2_jump_q, op2_jump_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  dec_ctrl_t         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  id_decode_comb #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_decode (
    .i_inst     (i_inst),
    .i_pc       (i_inst_addr),
    .i_rs1_data (i_reg1_data),
    .i_rs2_data (i_reg2_data),
    .o_wr_addr  (dec_wr_addr),
    .o_op1      (dec_op1),
    .o_op2      (dec_op2),
    .o_op1_jump (dec_op1_jump),
    .o_op2_jump (dec_op2_jump),
    .o_rs2_data (dec_rs2_data),
    .o_ctrl     (dec_ctrl),
    .o_rs1_used (rs1_used),
    .o_rs2_used (rs2_used)
  );

  assign o_reg1_raddr = REG_AW'(i_inst[19:15]);
  assign o_reg2_raddr = REG_AW'(i_inst[24:20]);

  assign hazard  = i_ex_load && (i_ex_rd != '0) &&
                   ((rs1_used && i_ex_rd == o_reg1_raddr) || (rs2_used && i_ex_rd == o_reg2_raddr));
  assign o_ready = !i_flush && !hazard && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;

  always_comb begin
    valid_d    = valid_q;
    wr_addr_d  = wr_addr_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op1_jump_d = op1_jump_q;
    op2_jump_d = op2_jump_q;
    rs2_data_d = rs2_data_q;
    ctrl_d     = ctrl_q;
    stall_d    = stall_q;

    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      wr_addr_d  = dec_wr_addr;
      op1_d      = dec_op1;
      op2_d      = dec_op2;
      op1_jump_d = dec_op1_jump;
      op2_jump_d = dec_op2_jump;
      rs2_data_d = dec_rs2_data;
      ctrl_d     = dec_ctrl;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    // A bubble is only counted when the slot would otherwise have been filled.
    if (!i_flush && i_valid && hazard && (!valid_q || i_ready) && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q    <= 1'b0;
      wr_addr_q  <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      op1_jump_q <= '0;
      op2_jump_q <= '0;
      rs2_data_q <= '0;
      ctrl_q     <= '{alu_op: ALU_NOP, default: '0};
      stall_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      wr_addr_q  <= wr_addr_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      op1_jump_q <= op1_jump_d;
      op2_jump_q <= op2_jump_d;
      rs2_data_q <= rs2_data_d;
      ctrl_q     <= ctrl_d;
      stall_q    <= stall_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_reg_we      = ctrl_q.we;
  assign o_reg_wr_addr = wr_addr_q;
  assign o_op1         = op1_q;
  assign o_op2         = op2_q;
  assign o_op1_jump    = op1_jump_q;
  assign o_op2_jump    = op2_jump_q;
  assign o_rs2_data    = rs2_data_q;
  assign o_alu_op      = ctrl_q.alu_op;
  assign o_is_load     = ctrl_q.is_load;
  assign o_is_store    = ctrl_q.is_store;
  assign o_is_branch   = ctrl_q.is_branch;
  assign o_illegal     = ctrl_q.illegal;
  assign o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe against an instruction-level reference model, plus directed cases.
// A second instance with a 2-bit stall counter exercises saturation.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  logic        i_clk = 1'b0, i_rst = 1'b0;
  logic        i_valid, i_ex_load, i_flush, i_ready;
  logic [31:0] i_inst, i_inst_addr, i_reg1_data, i_reg2_data;
  logic [4:0]  i_ex_rd;

  logic        o_ready, o_valid, o_reg_we, o_is_load, o_is_store, o_is_branch, o_illegal;
  logic [4:0]  o_reg1_raddr, o_reg2_raddr, o_reg_wr_addr, o_alu_op;
  logic [31:0] o_op1, o_op2, o_op1_jump, o_op2_jump, o_rs2_data;
  logic [15:0] o_stall_cnt;

  logic        s_ready, s_valid, s_reg_we, s_is_load, s_is_store, s_is_branch, s_illegal;
  logic [4:0]  s_reg1_raddr, s_reg2_raddr, s_reg_wr_addr, s_alu_op;
  logic [31:0] s_op1, s_op2, s_op1_jump, s_op2_jump, s_rs2_data;
  logic [1:0]  s_stall_cnt;

  always #5 i_clk = ~i_clk;

  id_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
    .i_inst_addr(i_inst_addr), .o_reg1_raddr(o_reg1_raddr), .o_reg2_raddr(o_reg2_raddr),
    .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_reg_we(o_reg_we),
    .o_reg_wr_addr(o_reg_wr_addr), .o_op1(o_op1), .o_op2(o_op2), .o_op1_jump(o_op1_jump),
    .o_op2_jump(o_op2_jump), .o_rs2_data(o_rs2_data), .o_alu_op(o_alu_op), .o_is_load(o_is_load),
    .o_is_store(o_is_store), .o_is_branch(o_is_branch), .o_illegal(o_illegal), .o_stall_cnt(o_stall_cnt)
  );

  id_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready), .i_inst(i_inst),
    .i_inst_addr(i_inst_addr), .o_reg1_raddr(s_reg1_raddr), .o_reg2_raddr(s_reg2_raddr),
    .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
    .i_flush(i_flush), .o_valid(s_valid), .i_ready(i_ready), .o_reg_we(s_reg_we),
    .o_reg_wr_addr(s_reg_wr_addr), .o_op1(s_op1), .o_op2(s_op2), .o_op1_jump(s_op1_jump),
    .o_op2_jump(s_op2_jump), .o_rs2_data(s_rs2_data), .o_alu_op(s_alu_op), .o_is_load(s_is_load),
    .o_is_store(s_is_store), .o_is_branch(s_is_branch), .o_illegal(s_illegal), .o_stall_cnt(s_stall_cnt)
  );

  int unsigned n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we, ld, st, br, ill, u1, u2;
    logic [4:0]  wa, alu;
    logic [31:0] op1, op2, j1, j2, rs2d;
  } bundle_t;

  // Instruction-level reference: what each instruction class must produce.
  function automatic bundle_t ref_decode(input logic [31:0] in, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
    bundle_t     b = '{default: 0};
    logic [6:0]  opc = in[6:0];
    logic [2:0]  f3 = in[14:12];
    logic [6:0]  f7 = in[31:25];
    logic [31:0] ii = 32'($signed(in) >>> 20);
    logic [31:0] is = {ii[31:5], in[11:7]};
    logic [31:0] ib = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
    logic [31:0] iu = {in[31:12], 12'h000};
    logic [31:0] ij = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
    logic [4:0]  base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [4:0]  brt  [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    logic        ok = 1'b1;
    case (opc)
      7'h00: ;
      7'h33: begin
        b.op1 = r1; b.op2 = r2; b.u1 = 1; b.u2 = 1; b.we = 1;
        if (f7 == 7'h00) b.alu = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) b.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) b.alu = ALU_SRA;
`ifdef JERISCV_M_EXT_EN
        else if (f7 == 7'h01) b.alu = 5'(ALU_MUL) + 5'(f3);
`endif
        else ok = 0;
      end
      7'h13: begin
        b.op1 = r1; b.op2 = ii; b.u1 = 1; b.we = 1; b.alu = base[f3];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00 || f7 == 7'h20);
          if (f7 == 7'h20) b.alu = ALU_SRA;
        end
      end
      7'h03: begin
        b.op1 = r1; b.op2 = ii; b.u1 = 1; b.we = 1; b.ld = 1; b.alu = ALU_ADD;
        ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin
        b.op1 = r1; b.op2 = is; b.rs2d = r2; b.u1 = 1; b.u2 = 1; b.st = 1; b.alu = ALU_ADD;
        ok = (f3 inside {3'd0, 3'd1, 3'd2});
      end
      7'h63: begin
        b.op1 = r1; b.op2 = r2; b.j1 = pc; b.j2 = ib; b.u1 = 1; b.u2 = 1; b.br = 1;
        b.alu = brt[f3]; ok = (f3 != 3'd2 && f3 != 3'd3);
      end
      7'h37: begin b.op2 = iu; b.we = 1; b.alu = ALU_ADD; end
      7'h17: begin b.op1 = pc; b.op2 = iu; b.we = 1; b.alu = ALU_ADD; end
      7'h6F: begin b.op1 = pc; b.op2 = 4; b.j1 = pc; b.j2 = ij; b.we = 1; b.alu = ALU_ADD; end
      7'h67: begin
        b.op1 = pc; b.op2 = 4; b.j1 = r1; b.j2 = ii; b.u1 = 1; b.we = 1; b.alu = ALU_ADD;
        ok = (f3 == 3'd0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      b = '{default: 0};
      b.ill = 1;
    end else if (opc != 7'h00) begin
      b.wa = in[11:7];
    end
    if (in[11:7] == 5'd0) b.we = 0;
    return b;
  endfunction

  function automatic logic ref_hazard(input bundle_t d, input logic [31:0] in,
                                      input logic ld, input logic [4:0] rd);
    return ld && rd != 0 && ((d.u1 && rd == in[19:15]) || (d.u2 && rd == in[24:20]));
  endfunction

  bundle_t     m_b;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  always @(posedge i_clk or negedge i_rst) begin
    bundle_t d;
    logic    hz, rdy, slot_free;
    if (!i_rst) begin
      m_valid = 0; m_cnt = 0; m_cnt2 = 0; m_b = '{default: 0};
    end else begin
      d = ref_decode(i_inst, i_inst_addr, i_reg1_data, i_reg2_data);
      hz = ref_hazard(d, i_inst, i_ex_load, i_ex_rd);
      slot_free = !m_valid || i_ready;
      rdy = !i_flush && !hz && slot_free;
      if (!i_flush && i_valid && hz && slot_free) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 1;
      end
      if (i_flush) m_valid = 0;
      else if (i_valid && rdy) begin m_valid = 1; m_b = d; end
      else if (m_valid && i_ready) m_valid = 0;
    end
  end

  always @(negedge i_clk) begin
    bundle_t d;
    logic    hz;
    if (!i_rst) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_cnt", o_stall_cnt, 0);
      chk("rst_alu", o_alu_op, ALU_NOP);
    end else begin
      d = ref_decode(i_inst, i_inst_addr, i_reg1_data, i_reg2_data);
      hz = ref_hazard(d, i_inst, i_ex_load, i_ex_rd);
      chk("ready", o_ready, !i_flush && !hz && (!m_valid || i_ready));
      chk("raddr1", o_reg1_raddr, i_inst[19:15]);
      chk("raddr2", o_reg2_raddr, i_inst[24:20]);
      chk("valid", o_valid, m_valid);
      chk("stall_cnt", o_stall_cnt, m_cnt);
      chk("stall_cnt_sat", s_stall_cnt, m_cnt2);
      if (m_valid) begin
        chk("we", o_reg_we, m_b.we);
        chk("wr_addr", o_reg_wr_addr, m_b.wa);
        chk("op1", o_op1, m_b.op1);
        chk("op2", o_op2, m_b.op2);
        chk("op1_jump", o_op1_jump, m_b.j1);
        chk("op2_jump", o_op2_jump, m_b.j2);
        chk("rs2_data", o_rs2_data, m_b.rs2d);
        chk("alu_op", o_alu_op, m_b.alu);
        chk("flags", {o_is_load, o_is_store, o_is_branch, o_illegal}, {m_b.ld, m_b.st, m_b.br, m_b.ill});
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
    logic [31:0] w = $urandom;
    int unsigned k = $urandom_range(0, 11);
    if (k == 10) return w;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if (k == 11) begin
      w[6:0] = 7'h33; w[31:25] = 7'h01;
    end else begin
      w[6:0] = opcs[k];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  localparam logic [31:0] ADDI_X1_X2_M1 = 32'hFFF1_0093;
  localparam logic [31:0] ADD_X3_X2_X4  = 32'h0041_01B3;
  localparam logic [31:0] JAL_X1_P8     = 32'h0080_00EF;
  localparam logic [31:0] MUL_X5_X6_X7  = 32'h0273_02B3;

  initial begin
    i_valid = 0; i_inst = 0; i_inst_addr = 0; i_reg1_data = 0; i_reg2_data = 0;
    i_ex_load = 0; i_ex_rd = 0; i_flush = 0; i_ready = 1;
    repeat (2) tick();
    chk("lit_rst_valid", o_valid, 0);
    chk("lit_rst_cnt", o_stall_cnt, 0);
    chk("lit_rst_alu", o_alu_op, ALU_NOP);
    i_rst = 1;
    #1 chk("lit_idle_ready", o_ready, 1);

    i_valid = 1; i_inst = ADDI_X1_X2_M1; i_reg1_data = 32'h10;
    #1 chk("lit_addi_raddr1", o_reg1_raddr, 2);
    tick();
    i_valid = 0;
    chk("lit_addi_valid", o_valid, 1);
    chk("lit_addi_op1", o_op1, 32'h10);
    chk("lit_addi_op2", o_op2, 32'hFFFF_FFFF);
    chk("lit_addi_we", o_reg_we, 1);
    chk("lit_addi_wa", o_reg_wr_addr, 1);

    i_valid = 1; i_inst = ADD_X3_X2_X4; i_reg2_data = 32'h5; i_ex_load = 1; i_ex_rd = 2;
    #1 chk("lit_hz_ready", o_ready, 0);
    tick();
    chk("lit_hz_bubble", o_valid, 0);
    chk("lit_hz_cnt", o_stall_cnt, 1);
    i_ex_load = 0;
    #1 chk("lit_hz_release_ready", o_ready, 1);
    tick();
    chk("lit_add_valid", o_valid, 1);
    chk("lit_add_wa", o_reg_wr_addr, 3);
    chk("lit_add_op2", o_op2, 32'h5);
    chk("lit_add_cnt", o_stall_cnt, 1);

    i_ready = 0; i_inst = ADDI_X1_X2_M1;
    repeat (3) begin
      #1 chk("lit_hold_ready", o_ready, 0);
      tick();
      chk("lit_hold_valid", o_valid, 1);
      chk("lit_hold_wa", o_reg_wr_addr, 3);
    end
    i_ready = 1;
    #1 chk("lit_resume_ready", o_ready, 1);
    tick();
    chk("lit_resume_wa", o_reg_wr_addr, 1);

    i_inst = JAL_X1_P8; i_inst_addr = 32'h100;
    tick();
    chk("lit_jal_op1", o_op1, 32'h100);
    chk("lit_jal_op2", o_op2, 4);
    chk("lit_jal_j1", o_op1_jump, 32'h100);
    chk("lit_jal_j2", o_op2_jump, 8);
    i_flush = 1;
    #1 chk("lit_flush_ready", o_ready, 0);
    tick();
    chk("lit_flush_valid", o_valid, 0);
    i_flush = 0;

    i_inst = MUL_X5_X6_X7;
    tick();
`ifdef JERISCV_M_EXT_EN
    chk("lit_mul_alu", o_alu_op, ALU_MUL);
    chk("lit_mul_we", o_reg_we, 1);
    chk("lit_mul_ill", o_illegal, 0);
`else
    chk("lit_mul_alu", o_alu_op, ALU_NOP);
    chk("lit_mul_we", o_reg_we, 0);
    chk("lit_mul_ill", o_illegal, 1);
`endif
    chk("lit_mul_valid", o_valid, 1);

    i_ready = 0; i_ex_load = 1; i_ex_rd = 6;
    #2 i_rst = 0;
    #1 chk("lit_async_valid", o_valid, 0);
    chk("lit_async_cnt", o_stall_cnt, 0);
    tick();
    i_rst = 1; i_ex_load = 0; i_ready = 1;

    for (int c = 0; c < 4000; c++) begin
      i_valid     = ($urandom_range(0, 9) < 8);
      i_inst      = rnd_inst();
      i_inst_addr = $urandom & 32'hFFFF_FFFC;
      i_reg1_data = $urandom;
      i_reg2_data = $urandom;
      i_ex_load   = ($urandom_range(0, 2) == 0);
      i_ex_rd     = 5'($urandom_range(0, 7));
      i_flush     = ($urandom_range(0, 19) == 0);
      i_ready     = ($urandom_range(0, 9) < 7);
      tick();
    end
    i_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
